// File: rtl/mrio_serial.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO, data register at BASE, status at BASE+1.
// Define MRIO_SERIAL_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mrio_serial #(
    parameter logic [15:0] BASE   = 16'hFF00,
    parameter int          CLKDIV = 16,
    parameter int          DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] ADDR,
    input  logic [15:0] D_IN,
    input  logic        STO,
    output logic [15:0] D_OUT,
    output logic        TX,
    output logic        BUSY
);

    localparam int              PW        = $clog2(DEPTH);
    localparam logic [15:0]     STAT_ADDR = BASE + 16'd1;
    localparam logic [15:0]     BAUD_LOAD = 16'(CLKDIV - 1);
    localparam logic [PW:0]     CNT_FULL  = (PW + 1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

`ifdef MRIO_SERIAL_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t          state_r;
    logic [15:0]     baud_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic [7:0]      mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;
    logic            ovf_r;
`ifdef MRIO_SERIAL_PARITY_EN
    logic            par_r;
`endif

    logic            wr_data_s;
    logic            wr_stat_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            bit_end_s;
    logic            busy_s;
    logic [15:0]     count_ext_s;
    logic [2:0]      cnt_sat_s;
    logic [7:0]      head_s;
    logic            unused_s;

    assign wr_data_s   = STO && (ADDR == BASE);
    assign wr_stat_s   = STO && (ADDR == STAT_ADDR);
    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == '0);
    assign push_s      = wr_data_s && !full_s;
    assign bit_end_s   = (baud_r == 16'd0);
    // A pop happens when idle, or exactly at the end of a stop bit, so frames run back to back.
    assign pop_s       = !empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s));
    assign busy_s      = (state_r != ST_IDLE) || !empty_s;
    assign count_ext_s = 16'(count_r);
    assign head_s      = mem_r[rd_ptr_r];
    assign unused_s    = ^D_IN[15:8];
    assign TX          = tx_r;
    assign BUSY        = busy_s;

    // Status register readback; every other address reads as zero.
    always_comb begin
        cnt_sat_s = (count_ext_s > 16'd7) ? 3'd7 : count_ext_s[2:0];
        if (ADDR == STAT_ADDR) begin
            D_OUT = {8'h00, 1'b0, cnt_sat_s, ovf_r, busy_s, empty_s, full_s};
        end else begin
            D_OUT = 16'h0000;
        end
    end

    // FIFO storage, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= D_IN[7:0];
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // Fullness is judged before the edge, so a coinciding pop does not rescue the write.
            if (wr_data_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_stat_s && D_IN[3]) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Transmit sequencer: start bit, eight data bits LSB first, optional parity, stop bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            baud_r    <= 16'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
`ifdef MRIO_SERIAL_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r   <= ST_START;
                        shift_r   <= head_s;
                        baud_r    <= BAUD_LOAD;
                        bit_cnt_r <= 3'd0;
                        tx_r      <= 1'b0;
`ifdef MRIO_SERIAL_PARITY_EN
                        par_r     <= ^head_s;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r <= ST_DATA;
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                        baud_r  <= BAUD_LOAD;
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_r <= BAUD_LOAD;
                        if (bit_cnt_r == 3'd7) begin
`ifdef MRIO_SERIAL_PARITY_EN
                            state_r <= ST_PARITY;
                            tx_r    <= par_r;
`else
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
`ifdef MRIO_SERIAL_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r <= ST_STOP;
                        tx_r    <= 1'b1;
                        baud_r  <= BAUD_LOAD;
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s && pop_s) begin
                        state_r   <= ST_START;
                        shift_r   <= head_s;
                        baud_r    <= BAUD_LOAD;
                        bit_cnt_r <= 3'd0;
                        tx_r      <= 1'b0;
`ifdef MRIO_SERIAL_PARITY_EN
                        par_r     <= ^head_s;
`endif
                    end else if (bit_end_s) begin
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                        baud_r  <= 16'd0;
                    end else begin
                        baud_r <= baud_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    baud_r  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mrio_serial.sv
// Directed and random stimulus for mrio_serial, checked cycle by cycle against a frame-timing model.
module tb_mrio_serial;

    localparam logic [15:0] BASE   = 16'hFF00;
    localparam int          CLKDIV = 4;
    localparam int          DEPTH  = 4;
`ifdef MRIO_SERIAL_PARITY_EN
    localparam int          NBITS  = 11;
`else
    localparam int          NBITS  = 10;
`endif
    localparam int          FRAME  = NBITS * CLKDIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] D_IN = 16'h0000;
    logic        STO = 1'b0;
    logic [15:0] D_OUT;
    logic        TX;
    logic        BUSY;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: bytes waiting, the frame on the line and when the line is free again.
    logic [7:0] q[$];
    logic       m_ovf     = 1'b0;
    int         cyc       = 0;
    int         free_at   = 0;
    int         cur_start = -100000;
    logic [7:0] cur_byte  = 8'h00;

    mrio_serial #(.BASE(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .D_IN(D_IN), .STO(STO),
        .D_OUT(D_OUT), .TX(TX), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        int idx;
        if (cyc < cur_start + FRAME) begin
            idx = (cyc - cur_start) / CLKDIV;
            if (idx == 0) return 1'b0;
            if (idx <= 8) return cur_byte[idx-1];
`ifdef MRIO_SERIAL_PARITY_EN
            if (idx == 9) return ^cur_byte;
`endif
            return 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        return (cyc < free_at) || (q.size() != 0);
    endfunction

    function automatic logic [15:0] m_status();
        int cnt;
        cnt = (q.size() > 7) ? 7 : q.size();
        return {8'h00, 1'b0, 3'(cnt), m_ovf, m_busy(), q.size() == 0, q.size() == DEPTH};
    endfunction

    // Drive one cycle of bus activity, advance the model by one edge, then compare outputs.
    task automatic step(input logic sto, input logic [15:0] addr, input logic [15:0] din);
        int pre;
        STO  = sto;
        ADDR = addr;
        D_IN = din;
        cyc++;
        pre = q.size();
        if (pre > 0 && cyc >= free_at) begin
            cur_byte  = q.pop_front();
            cur_start = cyc;
            free_at   = cyc + FRAME;
        end
        if (sto && addr == BASE) begin
            if (pre < DEPTH) q.push_back(din[7:0]);
            else m_ovf = 1'b1;
        end
        if (sto && addr == BASE + 16'd1 && din[3]) m_ovf = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("tx", {15'd0, TX}, {15'd0, exp_tx()});
        chk("busy", {15'd0, BUSY}, {15'd0, m_busy()});
        chk("dout", D_OUT, (addr == BASE + 16'd1) ? m_status() : 16'h0000);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf     = 1'b0;
        free_at   = 0;
        cur_start = -100000;
    endtask

    initial begin
        logic [9:0] fr29;
        int r;
        int p;
        logic [15:0] a;
        fr29 = {1'b1, 8'h55, 1'b0};

        // Reset state
        ADDR = BASE + 16'd1;
        repeat (3) @(negedge CLK);
        chk("rst_tx", {15'd0, TX}, 16'h0001);
        chk("rst_busy", {15'd0, BUSY}, 16'h0000);
        chk("rst_status", D_OUT, 16'h0002);
        RST = 1'b1;

        // Single byte 0x55 at CLKDIV=4
        step(1'b1, BASE, 16'h1255);
        chk("tx_before_start", {15'd0, TX}, 16'h0001);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, BASE + 16'd1, 16'h0000);
`ifndef MRIO_SERIAL_PARITY_EN
            chk("frame_55", {15'd0, TX}, {15'd0, fr29[k/CLKDIV]});
`endif
        end
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("busy_after_frame", {15'd0, BUSY}, 16'h0000);

        // Five back-to-back writes fill the FIFO without overflow
        for (int i = 0; i < 5; i++) step(1'b1, BASE, 16'(8'hA1 + i));
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("five_writes_status", D_OUT, 16'h0045);
        repeat (5 * FRAME + 4) step(1'b0, BASE + 16'd1, 16'h0000);
        chk("five_writes_drained", D_OUT, 16'h0002);

        // Six back-to-back writes overflow; clearing OVF
        for (int i = 0; i < 6; i++) step(1'b1, BASE, 16'(8'h30 + i));
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("six_writes_status", D_OUT, 16'h004D);
        step(1'b1, BASE + 16'd1, 16'h0008);
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("ovf_cleared", D_OUT, 16'h0045);
        repeat (5 * FRAME + 4) step(1'b0, BASE + 16'd1, 16'h0000);
        chk("six_writes_drained", D_OUT, 16'h0002);

`ifdef MRIO_SERIAL_PARITY_EN
        // Parity bit of 0x07 is 1; frame is eleven bit times
        step(1'b1, BASE, 16'h0007);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, BASE + 16'd1, 16'h0000);
            if (k == 9 * CLKDIV) chk("parity_07", {15'd0, TX}, 16'h0001);
        end
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("parity_frame_len", {15'd0, BUSY}, 16'h0000);
`endif

        // Reset in the middle of the data bits of 0x00, with more bytes queued
        step(1'b1, BASE, 16'h0000);
        step(1'b1, BASE, 16'h00C3);
        step(1'b1, BASE, 16'h003C);
        repeat (6) step(1'b0, BASE + 16'd1, 16'h0000);
        chk("mid_data_low", {15'd0, TX}, 16'h0000);
        #2 RST = 1'b0;
        #1 chk("async_rst_tx", {15'd0, TX}, 16'h0001);
        chk("async_rst_status", D_OUT, 16'h0002);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2 * FRAME) step(1'b0, BASE + 16'd1, 16'h0000);
        chk("no_frame_after_rst", {15'd0, TX}, 16'h0001);

        // Address decode
        step(1'b0, BASE, 16'h0000);
        chk("read_ff00", D_OUT, 16'h0000);
        step(1'b0, 16'hFF02, 16'h0000);
        chk("read_ff02", D_OUT, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000);
        chk("read_0000", D_OUT, 16'h0000);
        step(1'b1, 16'hFF02, 16'h00AA);
        step(1'b0, BASE + 16'd1, 16'h0000);
        chk("write_ff02_ignored", D_OUT, 16'h0002);

        // Random traffic: a dense phase that overflows, then a sparse phase
        for (int i = 0; i < 700; i++) begin
            p = (i < 300) ? 3 : 30;
            r = $urandom_range(0, 9);
            if (r < 5) a = BASE;
            else if (r < 8) a = BASE + 16'd1;
            else if (r == 8) a = 16'hFF02;
            else a = 16'($urandom);
            step($urandom_range(0, p - 1) == 0, a, 16'($urandom));
        end
        step(1'b1, BASE + 16'd1, 16'h0008);
        repeat (5 * FRAME + 4) step(1'b0, BASE + 16'd1, 16'h0000);
        chk("random_drained", D_OUT, 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
